shift_add_dot_accumulator: RTL and testbench
============================================

Name: shift_add_dot_accumulator

Overview:
Downstream consumer of the pipelined shift-add multiplier's product stream (o_result_valid/o_result). It sums groups of consecutive products into dot-product results and buffers completed sums in a small FIFO with a valid/ready output. The multiplier pipeline cannot stall, so this block never back-pressures its product input. It reports FIFO occupancy so the operand issuer can throttle, and flags lost sums.

Parameters:
PRODUCT_WIDTH, 16, width of incoming product (2 x multiplier operand width)
ACC_WIDTH, 24, accumulator and sum width; must be >= PRODUCT_WIDTH
LEN_WIDTH, 8, width of group-length input
FIFO_DEPTH, 4, completed-sum buffer entries; power of two, >= 2

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_clear  in  1  synchronous abort of the partial group; clears o_overflow
i_group_length  in  LEN_WIDTH  products per group, sampled on the first product of a group
i_product_valid  in  1  product strobe, one product per cycle, no stall
i_product  in  PRODUCT_WIDTH  unsigned product
o_sum_valid  out  1  FIFO head valid
i_sum_ready  in  1  consumer accepts head
o_sum  out  ACC_WIDTH  FIFO head sum
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
o_busy  out  1  partial group in progress (state ACCUM)
o_overflow  out  1  sticky: a completed sum was dropped

Behaviour:
- Reset (i_reset_n low, asynchronous): state IDLE, accumulator 0, remaining count 0, FIFO empty, o_sum_valid 0, o_sum 0, o_fifo_level 0, o_busy 0, o_overflow 0.
- States:
  - IDLE: no partial group.
  - ACCUM: partial group open; remaining count >= 1 product still expected.
- IDLE, on i_product_valid:
  - Latch L = i_group_length; L = 0 is treated as 1.
  - L = 1: push the zero-extended product this edge; stay IDLE.
  - L > 1: acc = product, remaining = L-1, go to ACCUM.
- ACCUM, on i_product_valid:
  - remaining > 1: acc += product, remaining decrements.
  - remaining = 1: push acc + product; go IDLE.
  - i_group_length is ignored while in ACCUM.
- Arithmetic: zero-extend the product to ACC_WIDTH. Addition wraps modulo 2^ACC_WIDTH; no saturation, no carry flag.
- Latency: the sum is written at the edge that samples the final product. o_sum_valid is high in the following cycle if the FIFO was empty.
- FIFO:
  - First-word-fall-through; o_sum is the head entry. o_sum_valid = (level != 0).
  - Pop when o_sum_valid && i_sum_ready.
  - Push and pop in the same edge are both honoured; level is unchanged.
  - Full with a simultaneous pop: push accepted, no overflow.
  - Full without a pop: the sum is dropped, o_overflow sets, FIFO contents untouched, state machine still returns to IDLE.
  - When empty, o_sum holds its last value; it is 0 after reset.
- i_clear (synchronous, highest priority for the accumulator path):
  - Forces IDLE, zeroes acc and remaining, clears o_overflow.
  - i_product_valid in the same cycle is discarded.
  - The FIFO is not flushed; a pop in the same cycle still occurs.
- Reset mid-group: partial sum and all FIFO contents are lost immediately.
- o_fifo_level and o_busy are registered state, not combinational from inputs.

Test Plan:
- Group length 3, products 2, 3, 4 on consecutive cycles, i_sum_ready=1 -> one sum 9; o_sum_valid high exactly 1 cycle after the product 4 edge; o_busy high for 2 cycles.
- Length 0 then length 1, products 0xFFFF and 7 -> two sums, 0x00FFFF then 0x000007; o_busy never asserts.
- ACC_WIDTH=16, length 2, products 0xFFFF, 0x0002 -> sum 0x0001 (wrap); o_overflow stays 0.
- i_sum_ready=0, five length-1 groups with values 1..5 -> level reaches 4, o_overflow sets on value 5. Drain yields 1, 2, 3, 4. A further i_clear drops o_overflow to 0.
- FIFO full with i_sum_ready=1 on the cycle the 5th sum completes -> no overflow, level stays 4, drained order is 1, 2, 3, 4, 5.
- Length 4, two products (10, 20), then i_clear asserted together with a valid product 30; then length 2 with products 5, 6 -> only sum 11 emitted. Separately, i_reset_n pulsed low mid-group -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/shift_add_dot_accumulator.sv
// rtl/shift_add_dot_accumulator.sv - groups multiplier products into dot-product sums and buffers them in a FWFT FIFO
module shift_add_dot_accumulator #(
    parameter int PRODUCT_WIDTH = 16,
    parameter int ACC_WIDTH     = 24,
    parameter int LEN_WIDTH     = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_clear,
    input  logic [LEN_WIDTH-1:0]          i_group_length,
    input  logic                          i_product_valid,
    input  logic [PRODUCT_WIDTH-1:0]      i_product,
    output logic                          o_sum_valid,
    input  logic                          i_sum_ready,
    output logic [ACC_WIDTH-1:0]          o_sum,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_busy,
    output logic                          o_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [LEN_WIDTH-1:0]   rem_q;
    logic [ACC_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]          rd_ptr_q;
    logic [PW-1:0]          wr_ptr_q;
    logic [LW-1:0]          level_q;
    logic                   overflow_q;
    logic [ACC_WIDTH-1:0]   last_q;

    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [ACC_WIDTH-1:0]   push_data;
    logic                   take;
    logic                   len_one;
    logic                   push_req;
    logic                   pop;
    logic                   full;
    logic                   push;
    logic                   drop;

    always_comb begin
        prod_ext  = ACC_WIDTH'(i_product);
        acc_sum   = acc_q + prod_ext;
        take      = i_product_valid && !i_clear;
        // A latched length of 0 behaves exactly like 1.
        len_one   = (i_group_length <= LEN_WIDTH'(1));
        push_req  = take && (((state_q == IDLE) && len_one) ||
                             ((state_q == ACCUM) && (rem_q == LEN_WIDTH'(1))));
        push_data = (state_q == IDLE) ? prod_ext : acc_sum;
        pop       = (level_q != '0) && i_sum_ready;
        full      = (level_q == LW'(FIFO_DEPTH));
        push      = push_req && (!full || pop);
        drop      = push_req && full && !pop;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
        end else if (i_clear) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
        end else if (i_product_valid) begin
            case (state_q)
                IDLE: begin
                    if (!len_one) begin
                        acc_q   <= prod_ext;
                        rem_q   <= i_group_length - LEN_WIDTH'(1);
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (rem_q == LEN_WIDTH'(1)) begin
                        acc_q   <= '0;
                        rem_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_sum;
                        rem_q <= rem_q - LEN_WIDTH'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // When full with a pop, wr_ptr equals rd_ptr: the head is read out before the write lands.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            last_q     <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (i_clear) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign o_sum_valid  = (level_q != '0);
    assign o_sum        = (level_q != '0) ? mem_q[rd_ptr_q] : last_q;
    assign o_fifo_level = level_q;
    assign o_busy       = (state_q == ACCUM);
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_shift_add_dot_accumulator.sv
// tb/tb_shift_add_dot_accumulator.sv - randomized self-checking bench against a queue-based reference model
module tb_shift_add_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [7:0]  gl;
    logic        pv;
    logic [15:0] prod;
    logic        rdy;

    logic        sv0, busy0, ovf0;
    logic [23:0] sum0;
    logic [2:0]  lvl0;
    logic        sv1, busy1, ovf1;
    logic [15:0] sum1;
    logic [2:0]  lvl1;

    always #5 clk = ~clk;

    shift_add_dot_accumulator #(.PRODUCT_WIDTH(16), .ACC_WIDTH(24), .LEN_WIDTH(8), .FIFO_DEPTH(4)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr), .i_group_length(gl),
        .i_product_valid(pv), .i_product(prod), .o_sum_valid(sv0), .i_sum_ready(rdy),
        .o_sum(sum0), .o_fifo_level(lvl0), .o_busy(busy0), .o_overflow(ovf0)
    );

    shift_add_dot_accumulator #(.PRODUCT_WIDTH(16), .ACC_WIDTH(16), .LEN_WIDTH(8), .FIFO_DEPTH(4)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr), .i_group_length(gl),
        .i_product_valid(pv), .i_product(prod), .o_sum_valid(sv1), .i_sum_ready(rdy),
        .o_sum(sum1), .o_fifo_level(lvl1), .o_busy(busy1), .o_overflow(ovf1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: index 0 is the 24-bit accumulator, index 1 the 16-bit one.
    longint m_q [2][$];
    longint m_acc [2];
    longint m_last [2];
    longint mask [2];
    bit     m_open;
    int     m_rem;
    bit     m_ovf;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k].delete();
            m_acc[k]  = 0;
            m_last[k] = 0;
        end
        m_open = 0;
        m_rem  = 0;
        m_ovf  = 0;
    endtask

    task automatic model_step();
        bit     do_push;
        longint val [2];
        int     len;
        do_push = 0;
        val[0] = 0;
        val[1] = 0;
        for (int k = 0; k < 2; k++) begin
            if (rdy && m_q[k].size() > 0) m_last[k] = m_q[k].pop_front();
        end
        if (clr) begin
            m_open = 0;
            m_rem  = 0;
            m_ovf  = 0;
            m_acc[0] = 0;
            m_acc[1] = 0;
        end else if (pv) begin
            if (!m_open) begin
                len = (gl == 0) ? 1 : int'(gl);
                if (len == 1) begin
                    do_push = 1;
                    for (int k = 0; k < 2; k++) val[k] = longint'(prod);
                end else begin
                    for (int k = 0; k < 2; k++) m_acc[k] = longint'(prod);
                    m_rem  = len - 1;
                    m_open = 1;
                end
            end else if (m_rem == 1) begin
                do_push = 1;
                for (int k = 0; k < 2; k++) val[k] = (m_acc[k] + longint'(prod)) & mask[k];
                m_open = 0;
                m_rem  = 0;
            end else begin
                for (int k = 0; k < 2; k++) m_acc[k] = (m_acc[k] + longint'(prod)) & mask[k];
                m_rem--;
            end
        end
        if (do_push) begin
            if (m_q[0].size() < 4) begin
                for (int k = 0; k < 2; k++) m_q[k].push_back(val[k]);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic compare_all();
        longint h0, h1;
        h0 = (m_q[0].size() != 0) ? m_q[0][0] : m_last[0];
        h1 = (m_q[1].size() != 0) ? m_q[1][0] : m_last[1];
        chk("sum_valid0", 32'(sv0), 32'(m_q[0].size() != 0));
        chk("sum0", 32'(sum0), 32'(h0));
        chk("level0", 32'(lvl0), 32'(m_q[0].size()));
        chk("busy0", 32'(busy0), 32'(m_open));
        chk("overflow0", 32'(ovf0), 32'(m_ovf));
        chk("sum_valid1", 32'(sv1), 32'(m_q[1].size() != 0));
        chk("sum1", 32'(sum1), 32'(h1));
        chk("level1", 32'(lvl1), 32'(m_q[1].size()));
        chk("busy1", 32'(busy1), 32'(m_open));
        chk("overflow1", 32'(ovf1), 32'(m_ovf));
    endtask

    task automatic step(input bit v, input logic [15:0] p, input logic [7:0] g, input bit r, input bit c);
        @(negedge clk);
        pv   = v;
        prod = p;
        gl   = g;
        rdy  = r;
        clr  = c;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        mask[0] = 64'hFF_FFFF;
        mask[1] = 64'hFFFF;
        rst_n = 1'b0;
        clr   = 1'b0;
        gl    = '0;
        pv    = 1'b0;
        prod  = '0;
        rdy   = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Group of three: 2 + 3 + 4
        step(1, 16'd2, 8'd3, 1, 0);
        step(1, 16'd3, 8'd0, 1, 0);
        step(1, 16'd4, 8'd0, 1, 0);
        chk("t1_sum", 32'(sum0), 32'd9);
        chk("t1_valid", 32'(sv0), 32'd1);
        step(0, 16'd0, 8'd0, 1, 0);

        // Length 0 and length 1 groups
        step(1, 16'hFFFF, 8'd0, 1, 0);
        chk("t2_first", 32'(sum0), 32'h00FFFF);
        step(1, 16'd7, 8'd1, 1, 0);
        chk("t2_second", 32'(sum0), 32'h000007);
        step(0, 16'd0, 8'd0, 1, 0);

        // Modular wrap on the 16-bit instance
        step(1, 16'hFFFF, 8'd2, 1, 0);
        step(1, 16'h0002, 8'd0, 1, 0);
        chk("t3_wrap16", 32'(sum1), 32'h0001);
        chk("t3_sum24", 32'(sum0), 32'h010001);
        step(0, 16'd0, 8'd0, 1, 0);

        // Overflow with consumer stalled
        for (int i = 1; i <= 5; i++) step(1, 16'(i), 8'd1, 0, 0);
        chk("t4_level", 32'(lvl0), 32'd4);
        chk("t4_ovf", 32'(ovf0), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("t4_drain", 32'(sum0), 32'(i));
            step(0, 16'd0, 8'd0, 1, 0);
        end
        step(0, 16'd0, 8'd0, 0, 1);
        chk("t4_clear_ovf", 32'(ovf0), 32'd0);

        // Full FIFO with simultaneous pop
        for (int i = 1; i <= 4; i++) step(1, 16'(i), 8'd1, 0, 0);
        step(1, 16'd5, 8'd1, 1, 0);
        chk("t5_level", 32'(lvl0), 32'd4);
        chk("t5_ovf", 32'(ovf0), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            chk("t5_drain", 32'(sum0), 32'(i));
            step(0, 16'd0, 8'd0, 1, 0);
        end

        // Clear aborts a partial group
        step(1, 16'd10, 8'd4, 1, 0);
        step(1, 16'd20, 8'd0, 1, 0);
        step(1, 16'd30, 8'd0, 1, 1);
        step(1, 16'd5, 8'd2, 1, 0);
        step(1, 16'd6, 8'd0, 1, 0);
        chk("t6_sum", 32'(sum0), 32'd11);
        chk("t6_level", 32'(lvl0), 32'd1);

        // Asynchronous reset mid-group with a buffered sum
        step(1, 16'd9, 8'd3, 0, 0);
        step(1, 16'd1, 8'd0, 0, 0);
        @(negedge clk);
        pv = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("t6_reset_sum", 32'(sum0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), 8'($urandom_range(0, 5)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
